// File: rtl/delay_calib_pkg.sv
// Shared types for the RX-clock delay-line calibration sequencer:
// FSM state encoding, the pass-window record and window arithmetic helpers.
package delay_calib_pkg;

    localparam int unsigned CALIB_NUM_STEPS = 16;
    localparam int unsigned CALIB_SEL_W     = $clog2(CALIB_NUM_STEPS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_TEST   = 3'd2,
        ST_EVAL   = 3'd3,
        ST_FINISH = 3'd4
    } calib_state_e;

    typedef struct packed {
        logic [CALIB_SEL_W-1:0] start;
        logic [CALIB_SEL_W:0]   len;
    } calib_win_t;

    localparam logic [CALIB_SEL_W:0] CALIB_LEN_ONE = (CALIB_SEL_W+1)'(1);

    // Centre tap of a window; start + len/2 never exceeds the last tap.
    function automatic logic [CALIB_SEL_W-1:0] win_centre(input calib_win_t win);
        return win.start + CALIB_SEL_W'(win.len >> 1'b1);
    endfunction

    // Strictly longer only, so an earlier window wins a tie.
    function automatic logic win_longer(input calib_win_t cand, input calib_win_t best);
        return (cand.len > best.len);
    endfunction

endpackage

// File: rtl/delay_calib_window.sv
// Run/best tracker: follows the current run of passing taps and keeps the
// longest (earliest on tie) run seen since the last clear.
module delay_calib_window
    import delay_calib_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   valid_i,
    input  logic                   pass_i,
    input  logic                   last_i,
    input  logic [CALIB_SEL_W-1:0] tap_i,
    output calib_win_t             best_o
);

    calib_win_t cur_q, cur_d;
    calib_win_t best_q, best_d;
    calib_win_t run_s;

    // Next-state for the current run and the best window.
    always_comb begin
        run_s  = cur_q;
        cur_d  = cur_q;
        best_d = best_q;
        if (clear_i) begin
            cur_d  = '0;
            best_d = '0;
        end else if (valid_i) begin
            if (pass_i) begin
                if (cur_q.len == '0) begin
                    run_s.start = tap_i;
                end else begin
                    run_s.start = cur_q.start;
                end
                run_s.len = cur_q.len + CALIB_LEN_ONE;
            end else begin
                run_s = cur_q;
            end
            // A fail ends the run; the last tap ends it with this verdict included.
            if (!pass_i || last_i) begin
                if (win_longer(run_s, best_q)) begin
                    best_d = run_s;
                end else begin
                    best_d = best_q;
                end
                cur_d = '0;
            end else begin
                cur_d = run_s;
            end
        end else begin
            cur_d  = cur_q;
            best_d = best_q;
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_q  <= '0;
            best_q <= '0;
        end else begin
            cur_q  <= cur_d;
            best_q <= best_d;
        end
    end

    assign best_o = best_q;

endmodule

// File: rtl/delay_calib_ctrl.sv
// Delay-line calibration sequencer: sweeps all taps, asks the PHY checker for a
// verdict at each, then programs the centre of the widest passing window.
module delay_calib_ctrl
    import delay_calib_pkg::*;
#(
    parameter int unsigned NUM_STEPS       = CALIB_NUM_STEPS,
    parameter int unsigned DELAY_SEL_WIDTH = $clog2(NUM_STEPS),
    parameter int unsigned SETTLE_CYCLES   = 8,
    parameter int unsigned DEFAULT_DELAY   = NUM_STEPS / 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       cfg_manual_i,
    input  logic [DELAY_SEL_WIDTH-1:0] cfg_delay_i,
    output logic [DELAY_SEL_WIDTH-1:0] delay_o,
    output logic                       test_req_o,
    input  logic                       test_ack_i,
    input  logic                       test_pass_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o,
    output logic [DELAY_SEL_WIDTH-1:0] win_lo_o,
    output logic [DELAY_SEL_WIDTH:0]   win_len_o
);

    localparam int unsigned SEL_W = DELAY_SEL_WIDTH;
    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [SEL_W-1:0] LAST_TAP    = SEL_W'(NUM_STEPS - 1);
    localparam logic [SEL_W-1:0] TAP_ONE     = SEL_W'(1);
    localparam logic [SEL_W-1:0] DEFAULT_SEL = SEL_W'(DEFAULT_DELAY);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    calib_state_e     state_q, state_d;
    logic [SEL_W-1:0] tap_q, tap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic [SEL_W-1:0] save_q, save_d;
    logic [SEL_W-1:0] delay_q, delay_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [SEL_W-1:0] win_lo_q, win_lo_d;
    logic [SEL_W:0]   win_len_q, win_len_d;

    logic       sweep_go_s;
    calib_win_t best_s;

    assign sweep_go_s = (state_q == ST_IDLE) && start_i && !cfg_manual_i;

    delay_calib_window u_window (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (sweep_go_s),
        .valid_i (state_q == ST_EVAL),
        .pass_i  (pass_q),
        .last_i  (tap_q == LAST_TAP),
        .tap_i   (tap_q),
        .best_o  (best_s)
    );

    // Sequencer next-state and next values of every registered output.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        save_d    = save_q;
        delay_d   = delay_q;
        done_d    = 1'b0;
        err_d     = err_q;
        win_lo_d  = win_lo_q;
        win_len_d = win_len_q;
        // Manual override aborts any sweep silently and drives the line directly.
        if (cfg_manual_i) begin
            state_d = ST_IDLE;
            delay_d = cfg_delay_i;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_APPLY;
                        tap_d   = '0;
                        cnt_d   = '0;
                        save_d  = delay_q;
                        delay_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_APPLY: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_TEST;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_TEST: begin
                    if (test_ack_i) begin
                        pass_d  = test_pass_i;
                        state_d = ST_EVAL;
                    end else begin
                        state_d = ST_TEST;
                    end
                end
                ST_EVAL: begin
                    if (tap_q == LAST_TAP) begin
                        state_d = ST_FINISH;
                    end else begin
                        tap_d   = tap_q + TAP_ONE;
                        cnt_d   = '0;
                        delay_d = tap_q + TAP_ONE;
                        state_d = ST_APPLY;
                    end
                end
                ST_FINISH: begin
                    if (best_s.len != '0) begin
                        delay_d = win_centre(best_s);
                        err_d   = 1'b0;
                    end else begin
                        delay_d = save_q;
                        err_d   = 1'b1;
                    end
                    win_lo_d  = best_s.start;
                    win_len_d = best_s.len;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
        req_d  = (state_d == ST_TEST);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            tap_q     <= '0;
            cnt_q     <= '0;
            pass_q    <= 1'b0;
            save_q    <= DEFAULT_SEL;
            delay_q   <= DEFAULT_SEL;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            win_lo_q  <= '0;
            win_len_q <= '0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            save_q    <= save_d;
            delay_q   <= delay_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            win_lo_q  <= win_lo_d;
            win_len_q <= win_len_d;
        end
    end

    assign delay_o    = delay_q;
    assign test_req_o = req_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = err_q;
    assign win_lo_o   = win_lo_q;
    assign win_len_o  = win_len_q;

endmodule

// File: tb/tb_delay_calib_ctrl.sv
// Self-checking bench for delay_calib_ctrl: directed window table, randomised
// sweeps against a window-scanning model, plus manual-abort and reset sequences.
module tb_delay_calib_ctrl;

    localparam int SETTLE = 4;
    localparam int NSTEP  = 16;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       cfg_manual_i = 1'b0;
    logic [3:0] cfg_delay_i = 4'd0;
    logic [3:0] delay_o;
    logic       test_req_o;
    logic       test_ack_i = 1'b0;
    logic       test_pass_i = 1'b0;
    logic       busy_o, done_o, error_o;
    logic [3:0] win_lo_o;
    logic [4:0] win_len_o;

    int n_total = 0;
    int n_pass  = 0;

    delay_calib_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .cfg_manual_i(cfg_manual_i), .cfg_delay_i(cfg_delay_i),
        .delay_o(delay_o), .test_req_o(test_req_o),
        .test_ack_i(test_ack_i), .test_pass_i(test_pass_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .win_lo_o(win_lo_o), .win_len_o(win_len_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mask;
        int          lo;
        int          len;
        int          dly;
        int          err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: scan the verdict mask for maximal runs, keep the first longest.
    task automatic ref_window(input logic [15:0] mask, input int prev_dly,
                              output int lo, output int len, output int dly, output int err);
        int i, j;
        lo = 0; len = 0; i = 0;
        while (i < NSTEP) begin
            if (mask[i]) begin
                j = i;
                while (j < NSTEP && mask[j]) j++;
                if (j - i > len) begin
                    len = j - i;
                    lo  = i;
                end
                i = j;
            end else begin
                i++;
            end
        end
        if (len > 0) begin
            dly = lo + len / 2;
            err = 0;
        end else begin
            dly = prev_dly;
            err = 1;
        end
    endtask

    // Runs one sweep acting as the PHY checker; returns edges from start to done.
    task automatic run_sweep(input logic [15:0] mask, input bit rnd,
                             output int cyc, output int exp_cyc, output int viol);
        int  wait_n, d, settle, last_d;
        bit  drove, prev_req, got_done;
        cyc = 0; exp_cyc = 1; viol = 0; wait_n = -1;
        drove = 1'b0; prev_req = 1'b0; got_done = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        settle = 0;
        last_d = int'(delay_o);
        while (!got_done && cyc < 400) begin
            if (cyc > 0) begin
                if (int'(delay_o) != last_d) begin
                    settle = 0;
                    last_d = int'(delay_o);
                end else begin
                    settle++;
                end
            end
            if (drove && test_req_o) viol++;
            if (!drove && prev_req && !test_req_o) viol++;
            if (test_req_o && !prev_req && settle != SETTLE) viol++;
            if (done_o) got_done = 1'b1;
            drove = 1'b0;
            if (rnd) begin
                test_ack_i  = 1'($urandom_range(1, 0));
                test_pass_i = 1'($urandom_range(1, 0));
            end else begin
                test_ack_i  = 1'b0;
                test_pass_i = 1'b0;
            end
            if (test_req_o) begin
                test_ack_i = 1'b0;
                if (wait_n < 0) begin
                    d = rnd ? int'($urandom_range(10, 1)) : 1;
                    wait_n = d - 1;
                    exp_cyc += SETTLE + d + 1;
                end else begin
                    wait_n--;
                end
                if (wait_n == 0) begin
                    test_ack_i  = 1'b1;
                    test_pass_i = mask[delay_o];
                    drove       = 1'b1;
                    wait_n      = -1;
                end
            end
            start_i  = rnd && busy_o && !done_o && ($urandom_range(15, 0) == 0);
            prev_req = test_req_o;
            if (!got_done) begin
                tick();
                cyc++;
            end
        end
        test_ack_i = 1'b0;
        start_i    = 1'b0;
        if (!got_done) cyc = -1;
    endtask

    initial begin
        vec_t tbl[7];
        int   cyc, exp_cyc, viol, model_dly;
        int   e_lo, e_len, e_dly, e_err, k;
        logic [15:0] m;

        tbl[0] = '{16'h0000,  0,  0,  8, 1};
        tbl[1] = '{16'h03F0,  4,  6,  7, 0};
        tbl[2] = '{16'h7C0E, 10,  5, 12, 0};
        tbl[3] = '{16'h071C,  2,  3,  3, 0};
        tbl[4] = '{16'hFFFF,  0, 16,  8, 0};
        tbl[5] = '{16'h8000, 15,  1, 15, 0};
        tbl[6] = '{16'h0000,  0,  0, 15, 1};

        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        chk("rst_delay", int'(delay_o), 8);
        chk("rst_req", int'(test_req_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(error_o), 0);
        chk("rst_lo", int'(win_lo_o), 0);
        chk("rst_len", int'(win_len_o), 0);

        for (int i = 0; i < 7; i++) begin
            run_sweep(tbl[i].mask, 1'b0, cyc, exp_cyc, viol);
            chk($sformatf("tbl%0d_cycles", i), cyc, 97);
            chk($sformatf("tbl%0d_lo", i), int'(win_lo_o), tbl[i].lo);
            chk($sformatf("tbl%0d_len", i), int'(win_len_o), tbl[i].len);
            chk($sformatf("tbl%0d_delay", i), int'(delay_o), tbl[i].dly);
            chk($sformatf("tbl%0d_err", i), int'(error_o), tbl[i].err);
            chk($sformatf("tbl%0d_proto", i), viol, 0);
        end
        model_dly = 15;

        e_lo = 0; e_len = 0; e_err = 1;
        for (int r = 0; r < 6; r++) begin
            m = 16'($urandom());
            if (r == 2) m = 16'h0000;
            if (r == 4) m = m | 16'h0FF0;
            ref_window(m, model_dly, e_lo, e_len, e_dly, e_err);
            run_sweep(m, 1'b1, cyc, exp_cyc, viol);
            chk($sformatf("rnd%0d_cycles", r), cyc, exp_cyc);
            chk($sformatf("rnd%0d_lo", r), int'(win_lo_o), e_lo);
            chk($sformatf("rnd%0d_len", r), int'(win_len_o), e_len);
            chk($sformatf("rnd%0d_delay", r), int'(delay_o), e_dly);
            chk($sformatf("rnd%0d_err", r), int'(error_o), e_err);
            chk($sformatf("rnd%0d_proto", r), viol, 0);
            model_dly = e_dly;
        end

        // Manual override mid-sweep at tap 6.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        k = 0;
        while (!(busy_o && delay_o == 4'd6) && k < 200) begin
            test_ack_i  = test_req_o;
            test_pass_i = 1'b1;
            tick();
            k++;
        end
        chk("abort_reach_tap6", int'(k < 200), 1);
        test_ack_i   = 1'b0;
        cfg_manual_i = 1'b1;
        cfg_delay_i  = 4'd3;
        tick();
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_req", int'(test_req_o), 0);
        tick();
        chk("manual_delay", int'(delay_o), 3);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("manual_start_ignored", int'(busy_o), 0);
        cfg_manual_i = 1'b0;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done_o || busy_o) k++;
        end
        chk("abort_no_done", k, 0);
        chk("manual_hold", int'(delay_o), 3);
        chk("abort_lo_kept", int'(win_lo_o), e_lo);
        chk("abort_len_kept", int'(win_len_o), e_len);
        chk("abort_err_kept", int'(error_o), e_err);

        // Reset while waiting in TEST, with an ack pending on the reset edge.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        k = 0;
        while (!test_req_o && k < 50) begin
            tick();
            k++;
        end
        chk("rst_reach_test", int'(test_req_o), 1);
        rst_i       = 1'b1;
        test_ack_i  = 1'b1;
        test_pass_i = 1'b1;
        tick();
        rst_i      = 1'b0;
        test_ack_i = 1'b0;
        chk("midrst_delay", int'(delay_o), 8);
        chk("midrst_req", int'(test_req_o), 0);
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_done", int'(done_o), 0);
        chk("midrst_err", int'(error_o), 0);
        chk("midrst_lo", int'(win_lo_o), 0);
        chk("midrst_len", int'(win_len_o), 0);
        repeat (3) tick();
        chk("midrst_stays_idle", int'(busy_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/delay_calib_ctrl.md
Name: delay_calib_ctrl

Overview:
Calibration sequencer for the macro-cell configurable delay line on the hyperbus RX clock path. On request it sweeps every delay setting 0..NUM_STEPS-1. At each setting it waits for the line to settle, then asks an external tester (PHY training-pattern checker) for a pass/fail verdict. It then programs the centre of the widest contiguous passing window. It also provides a software manual override and reports the window found.

Parameters:
NUM_STEPS, 16, number of delay taps; power of two, >= 2
DELAY_SEL_WIDTH, $clog2(NUM_STEPS), derived; width of delay select
SETTLE_CYCLES, 8, cycles to wait after each delay change before testing; >= 1
DEFAULT_DELAY, NUM_STEPS/2, delay select applied out of reset

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  single-cycle pulse; starts a sweep when idle
cfg_manual_i  in  1  manual override enable
cfg_delay_i  in  DELAY_SEL_WIDTH  manual delay select
delay_o  out  DELAY_SEL_WIDTH  to delay line delay_i
test_req_o  out  1  request a pass/fail check at current delay
test_ack_i  in  1  check finished; valid with test_pass_i
test_pass_i  in  1  check verdict; 1 = pass
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle pulse at sweep completion
error_o  out  1  sticky: last sweep found no passing tap
win_lo_o  out  DELAY_SEL_WIDTH  first tap of best window
win_len_o  out  DELAY_SEL_WIDTH+1  length of best window (0..NUM_STEPS)

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high. All state is sampled on the rising edge of clk_i.
- Reset values: delay_o=DEFAULT_DELAY, test_req_o=0, busy_o=0, done_o=0, error_o=0, win_lo_o=0, win_len_o=0; FSM in IDLE.
- FSM states and transitions:
  - IDLE: start_i && !cfg_manual_i -> APPLY, with tap=0 and run/best trackers cleared.
  - APPLY: delay_o=tap. Stay exactly SETTLE_CYCLES cycles, then -> TEST.
  - TEST: test_req_o=1. Leave when test_ack_i=1 is sampled; the verdict is captured in that cycle. -> EVAL. test_req_o is 0 from the next cycle. Ack may arrive in the first TEST cycle. test_ack_i outside TEST is ignored.
  - EVAL (1 cycle):
    - pass: if cur_len==0 then cur_start=tap; cur_len++.
    - fail: close run.
    - Close run: if cur_len > best_len (strictly), best<=cur; then cur_len=0.
    - If tap==NUM_STEPS-1, close the run using this step's result included -> FINISH. Otherwise tap++ -> APPLY.
  - FINISH (1 cycle):
    - best_len>0: delay_o = best_start + (best_len>>1), error_o=0.
    - best_len==0: delay_o = value held before the sweep, error_o=1.
    - In both cases: win_lo_o/win_len_o updated, done_o=1 -> IDLE.
- busy_o=1 in every state except IDLE.
- Ties between equal-length windows keep the earlier, lower-tap window.
- Arithmetic: tap counter is DELAY_SEL_WIDTH bits and never wraps past NUM_STEPS-1. Run/best lengths are DELAY_SEL_WIDTH+1 bits (all-pass gives NUM_STEPS). The centre computation cannot overflow.
- Per-step latency: SETTLE_CYCLES + ack latency (>=1) + 1. Minimum full sweep: NUM_STEPS*(SETTLE_CYCLES+2) + 1 cycles from start to done_o.
- Manual override:
  - While cfg_manual_i=1, delay_o follows cfg_delay_i (registered, 1-cycle latency) and start_i is ignored.
  - If cfg_manual_i rises mid-sweep, the sweep aborts to IDLE next cycle: test_req_o=0, no done_o, window outputs unchanged.
  - On deassert, delay_o holds the last manual value.
- start_i while busy is ignored.
- rst_i mid-sweep returns all outputs to reset values next edge; a pending ack is discarded.
- error_o clears only at the next successful FINISH or on reset.

Decomposition:
- Package delay_calib_pkg holds the FSM state enum (IDLE, APPLY, TEST, EVAL, FINISH) and a window struct (start: DELAY_SEL_WIDTH bits, len: DELAY_SEL_WIDTH+1 bits), parameterised via localparams derived in the module.
- One natural sub-module: delay_calib_window. It is the run/best tracker, with inputs tap, pass, valid, last, clear, and outputs best start/len.
- The FSM and settle counter stay in the top module.

Test Plan:
- NUM_STEPS=16, SETTLE=4, ack 1 cycle after req; taps 4..9 pass -> done_o after 16*6+1=97 cycles, win_lo=4, win_len=6, delay_o=7, error_o=0.
- Pass on taps 1..3 and 10..14 -> win_lo=10, win_len=5, delay_o=12. Pass on 2..4 and 8..10 (tie) -> win_lo=2, delay_o=3.
- All taps pass -> win_lo=0, win_len=16, delay_o=8. Only tap 15 passes -> window closed at last step: win_lo=15, win_len=1, delay_o=15.
- No tap passes; pre-sweep delay_o=8 -> error_o=1, delay_o=8, win_len=0. Then a passing sweep -> error_o=0.
- Ack delay randomised 1..10 cycles; check test_req_o held until ack, settle gap exactly 4 cycles after each delay_o change, start_i mid-sweep ignored.
- cfg_manual_i=1 with cfg_delay_i=3 at tap 6 -> next cycle busy_o=0, test_req_o=0, delay_o=3 one cycle later, no done_o. rst_i mid-TEST -> delay_o=8, all flags 0.
